// File: rtl/booth_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the Booth
// product-accumulate datapath.
package booth_pkg;

  localparam int PW = 16;
  localparam int AW = 20;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Limits are returned 64 bits wide; callers cast down to their own width.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational W-bit signed saturating adder; overflow flags a clamp.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int W = AW
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] SMAX = W'(sat_max(W));
  localparam logic [W-1:0] SMIN = W'(sat_min(W));

  logic [W:0] full;

  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  // Top two bits disagree only when the true sum left the W-bit range;
  // the extra sign bit tells which way it went.
  always_comb begin
    ovf_o = full[W] ^ full[W-1];
    sum_o = full[W-1:0];
    if (ovf_o) sum_o = full[W] ? SMIN : SMAX;
  end

endmodule

// File: rtl/booth_prod_accum.sv
// Accumulates n_terms signed products into a saturating accumulator and
// presents the sum with a sticky overflow flag on a valid/ready handshake.
module booth_prod_accum
  import booth_pkg::*;
#(
  parameter int PW = booth_pkg::PW,
  parameter int AW = booth_pkg::AW,
  parameter int CW = booth_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] n_terms,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [PW-1:0] p,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [AW-1:0] r,
  output logic          ovf,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;

  logic [AW-1:0] p_ext, sum;
  logic          add_ovf;

  assign p_ext = {{(AW-PW){p[PW-1]}}, p};

  booth_sat_add #(.W(AW)) u_add (
    .a_i   (acc_q),
    .b_i   (p_ext),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  // Every output comes from registered state only.
  assign p_ready = (state_q == ACC);
  assign r_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign r       = acc_q;
  assign ovf     = sat_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = n_terms;
          state_d = (n_terms == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (p_valid) begin
          acc_d = sum;
          sat_d = sat_q | add_ovf;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
// Directed bench: stimulus queues expected results, a monitor pops and
// compares them on every result handshake.
module tb_booth_prod_accum;

  localparam int PW = 16;
  localparam int AW = 20;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] n_terms;
  logic          p_valid;
  logic          p_ready;
  logic [PW-1:0] p;
  logic          r_valid;
  logic          r_ready;
  logic [AW-1:0] r;
  logic          ovf;
  logic          busy;

  booth_prod_accum #(.PW(PW), .AW(AW), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .n_terms (n_terms),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p       (p),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r       (r),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: result handshakes and product handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && p_valid && p_ready) hs_cnt++;
    if (rst_n && r_valid && r_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got r=%0d ovf=%0b with nothing expected",
                 $signed(r), ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ($signed(r) !== e.r || ovf !== e.ovf) begin
          n_err++;
          $display("FAIL result: got r=%0d ovf=%0b expected r=%0d ovf=%0b",
                   $signed(r), ovf, e.r, e.ovf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input bit push, input int er, input bit eo);
    exp_t e;
    if (push) begin
      e.r = er;
      e.ovf = eo;
      exp_q.push_back(e);
    end
    start = 1'b1;
    n_terms = CW'(n);
    tick();
    start = 1'b0;
    n_terms = '0;
  endtask

  task automatic feed(input int v, input int gap);
    p = PW'(v);
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    p = '0;
    repeat (gap) tick();
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int r_hold;
    rst_n = 1'b0; start = 1'b0; n_terms = '0; p_valid = 1'b0; p = '0; r_ready = 1'b1;
    repeat (2) tick();
    chk("rst_p_ready", int'(p_ready), 0);
    chk("rst_r_valid", int'(r_valid), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Basic sum with latency and busy window
    chk("basic_busy_before", int'(busy), 0);
    start_run(3, 1, 57, 0);
    chk("basic_busy_after_start", int'(busy), 1);
    chk("basic_p_ready", int'(p_ready), 1);
    feed(100, 0); feed(-50, 0);
    chk("basic_no_early_valid", int'(r_valid), 0);
    feed(7, 0);
    chk("basic_latency", int'(r_valid), 1);
    chk("basic_busy_in_done", int'(busy), 1);
    drain("basic");
    chk("basic_busy_idle", int'(busy), 0);
    chk("basic_r_valid_drop", int'(r_valid), 0);
    chk("basic_r_kept", $signed(r), 57);
    tick();

    // Positive saturation then recovery by one
    start_run(18, 1, 524286, 1);
    for (int i = 0; i < 16; i++) feed(32767, 0);
    chk("pos_acc16", $signed(r), 524272);
    chk("pos_ovf16", int'(ovf), 0);
    feed(32767, 0);
    chk("pos_clamp", $signed(r), 524287);
    chk("pos_ovf17", int'(ovf), 1);
    feed(-1, 0);
    drain("pos");
    tick();

    // Negative saturation
    start_run(17, 1, -524288, 1);
    for (int i = 0; i < 17; i++) feed(-32768, 0);
    drain("neg");
    tick();

    // Zero terms with backpressure; start/p_valid pulses must be ignored
    r_ready = 1'b0;
    start_run(0, 1, 0, 0);
    chk("zero_r_valid", int'(r_valid), 1);
    r_hold = int'(r);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); n_terms = 8'd5; p_valid = 1'b1; p = 16'd123;
      tick();
      chk("bp_r_stable", int'(r), r_hold);
      chk("bp_r_valid", int'(r_valid), 1);
      chk("bp_p_ready", int'(p_ready), 0);
    end
    start = 1'b0; n_terms = '0; p_valid = 1'b0; p = '0;
    r_ready = 1'b1;
    drain("zero");
    chk("zero_idle", int'(busy), 0);
    tick();
    chk("zero_no_queued_start", int'(busy), 0);

    // Bubbles between products
    hs_cnt = 0;
    start_run(4, 1, 10000, 0);
    feed(1000, 2); feed(2000, 2); feed(3000, 2); feed(4000, 0);
    drain("bubble");
    chk("bubble_handshakes", hs_cnt, 4);
    tick();

    // Reset mid-run discards the partial sum
    start_run(4, 0, 0, 0);
    feed(5, 0); feed(6, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_r", int'(r), 0);
    chk("midrst_r_valid", int'(r_valid), 0);
    chk("midrst_p_ready", int'(p_ready), 0);
    chk("midrst_ovf", int'(ovf), 0);
    tick();
    start_run(2, 1, 7, 0);
    feed(3, 0); feed(4, 0);
    drain("after_rst");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
